// File: rtl/fft_pkg.sv
// Shared constants, types and packing helpers for the FFT front end.
package fft_pkg;

   localparam int unsigned FFT_N    = 16;
   localparam int unsigned SAMPLE_W = 16;

   typedef struct packed {
      logic signed [SAMPLE_W-1:0] re;
      logic signed [SAMPLE_W-1:0] im;
   } cplx_t;

   // Selects one of the two ping-pong banks.
   typedef enum logic {
      BANK0 = 1'b0,
      BANK1 = 1'b1
   } bank_t;

   // Low bit position of sample k on a flat bus of w-bit lanes.
   function automatic int unsigned idx_slice(input int unsigned k,
                                             input int unsigned w = SAMPLE_W);
      return k * w;
   endfunction

   function automatic bank_t other_bank(input bank_t b);
      return (b == BANK0) ? BANK1 : BANK0;
   endfunction

endpackage

// File: rtl/framer_bank.sv
// N-entry sample store for one half of the ping-pong buffer.
// Contents are not reset; they are only meaningful once a bank is full.
module framer_bank
   import fft_pkg::*;
#(
   parameter int unsigned N = FFT_N,
   parameter int unsigned W = SAMPLE_W
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [$clog2(N)-1:0] widx,
   input  logic [W-1:0]         wre,
   input  logic [W-1:0]         wim,
   output logic [N*W-1:0]       rd_re,
   output logic [N*W-1:0]       rd_im
);

   localparam int unsigned IW = $clog2(N);

   // Write the addressed lane; every lane is always visible on the flat buses.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned k = 0; k < N; k++) begin
            if (widx == IW'(k)) begin
               rd_re[idx_slice(k, W) +: W] <= wre;
               rd_im[idx_slice(k, W) +: W] <= wim;
            end
         end
      end
   end

endmodule

// File: rtl/fft_input_framer.sv
// Serial-to-parallel framer: collects N complex samples into a natural-order
// frame using two ping-pong banks and presents it as registered flat buses.
module fft_input_framer
   import fft_pkg::*;
#(
   parameter int unsigned N = FFT_N,
   parameter int unsigned W = SAMPLE_W
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           s_valid,
   output logic           s_ready,
   input  logic [W-1:0]   s_re,
   input  logic [W-1:0]   s_im,
   input  logic           s_last,
   output logic [N*W-1:0] frame_re,
   output logic [N*W-1:0] frame_im,
   output logic           frame_valid,
   input  logic           frame_ready,
   output logic           err_pulse
);

   localparam int unsigned   IW       = $clog2(N);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   bank_t          wr_bank, wr_bank_nxt;
   bank_t          rd_bank, rd_bank_nxt;
   logic [IW-1:0]  wr_idx, wr_idx_nxt;
   logic [1:0]     bank_full, bank_full_nxt;
   logic           err_nxt;

   logic           accept;
   logic           at_last;
   logic           fill_done;
   logic           consume;
   logic           load_out;
   logic           we0, we1;
   logic [N*W-1:0] b0_re, b0_im, b1_re, b1_im;
   logic [N*W-1:0] src_re, src_im;

   assign accept      = s_valid && s_ready;
   assign at_last     = (wr_idx == LAST_IDX);
   assign fill_done   = accept && at_last;
   assign frame_valid = bank_full[rd_bank];
   assign consume     = frame_valid && frame_ready;

   assign we0 = accept && (wr_bank == BANK0);
   assign we1 = accept && (wr_bank == BANK1);

   framer_bank #(
      .N (N),
      .W (W)
   ) u_bank0 (
      .clk   (clk),
      .we    (we0),
      .widx  (wr_idx),
      .wre   (s_re),
      .wim   (s_im),
      .rd_re (b0_re),
      .rd_im (b0_im)
   );

   framer_bank #(
      .N (N),
      .W (W)
   ) u_bank1 (
      .clk   (clk),
      .we    (we1),
      .widx  (wr_idx),
      .wre   (s_re),
      .wim   (s_im),
      .rd_re (b1_re),
      .rd_im (b1_im)
   );

   // Next-state for write pointer, read pointer, full flags and error strobe.
   always_comb begin
      wr_idx_nxt    = wr_idx;
      wr_bank_nxt   = wr_bank;
      rd_bank_nxt   = rd_bank;
      bank_full_nxt = bank_full;
      err_nxt       = 1'b0;

      if (accept) begin
         if (at_last) begin
            bank_full_nxt[wr_bank] = 1'b1;
            wr_idx_nxt             = '0;
            wr_bank_nxt            = other_bank(wr_bank);
            err_nxt                = !s_last;
         end else if (s_last) begin
            // Early last: drop the partial frame and restart the same bank.
            wr_idx_nxt = '0;
            err_nxt    = 1'b1;
         end else begin
            wr_idx_nxt = wr_idx + IW'(1);
         end
      end

      // A full bank never accepts writes, so this cannot collide with the fill above.
      if (consume) begin
         bank_full_nxt[rd_bank] = 1'b0;
         rd_bank_nxt            = other_bank(rd_bank);
      end
   end

   // Pick the frame that will be presented next cycle and decide whether to load it.
   always_comb begin
      src_re = (rd_bank_nxt == BANK1) ? b1_re : b0_re;
      src_im = (rd_bank_nxt == BANK1) ? b1_im : b0_im;
      // The final sample is being written this very edge, so bypass it from the input.
      if (fill_done && (wr_bank == rd_bank_nxt)) begin
         src_re[idx_slice(N - 1, W) +: W] = s_re;
         src_im[idx_slice(N - 1, W) +: W] = s_im;
      end
      load_out = bank_full_nxt[rd_bank_nxt] && (!frame_valid || consume);
   end

   // Control state registers; s_ready is registered from the next-state flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_bank   <= BANK0;
         rd_bank   <= BANK0;
         wr_idx    <= '0;
         bank_full <= '0;
         s_ready   <= 1'b1;
         err_pulse <= 1'b0;
      end else begin
         wr_bank   <= wr_bank_nxt;
         rd_bank   <= rd_bank_nxt;
         wr_idx    <= wr_idx_nxt;
         bank_full <= bank_full_nxt;
         s_ready   <= !bank_full_nxt[wr_bank_nxt];
         err_pulse <= err_nxt;
      end
   end

   // Output frame registers, held until the next frame becomes presentable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_re <= '0;
         frame_im <= '0;
      end else if (load_out) begin
         frame_re <= src_re;
         frame_im <= src_im;
      end
   end

endmodule

// File: tb/tb_fft_input_framer.sv
// Scenario bench for fft_input_framer with a frame scoreboard.
module tb_fft_input_framer;
   import fft_pkg::*;

   localparam int unsigned N = 16;
   localparam int unsigned W = 16;

   logic           clk;
   logic           rst_n;
   logic           s_valid;
   logic           s_ready;
   logic [W-1:0]   s_re;
   logic [W-1:0]   s_im;
   logic           s_last;
   logic [N*W-1:0] frame_re;
   logic [N*W-1:0] frame_im;
   logic           frame_valid;
   logic           frame_ready;
   logic           err_pulse;

   int tests = 0;
   int fails = 0;
   bit mon_en = 0;

   // Scoreboard: completed frames waiting to be consumed.
   logic [N*W-1:0] sb_re[$];
   logic [N*W-1:0] sb_im[$];
   logic [N*W-1:0] m_re, m_im;
   int unsigned    m_idx;
   logic           exp_err;

   fft_input_framer #(
      .N (N),
      .W (W)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .s_valid     (s_valid),
      .s_ready     (s_ready),
      .s_re        (s_re),
      .s_im        (s_im),
      .s_last      (s_last),
      .frame_re    (frame_re),
      .frame_im    (frame_im),
      .frame_valid (frame_valid),
      .frame_ready (frame_ready),
      .err_pulse   (err_pulse)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   // Reference model: assemble accepted samples, push frames, pop on consume.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sb_re.delete();
         sb_im.delete();
         m_idx   = 0;
         exp_err = 1'b0;
         m_re    = '0;
         m_im    = '0;
      end else begin
         exp_err = 1'b0;
         if (frame_valid && frame_ready && sb_re.size() != 0) begin
            void'(sb_re.pop_front());
            void'(sb_im.pop_front());
         end
         if (s_valid && s_ready) begin
            m_re[m_idx*W +: W] = s_re;
            m_im[m_idx*W +: W] = s_im;
            if (m_idx == N - 1) begin
               sb_re.push_back(m_re);
               sb_im.push_back(m_im);
               exp_err = !s_last;
               m_idx   = 0;
            end else if (s_last) begin
               exp_err = 1'b1;
               m_idx   = 0;
            end else begin
               m_idx++;
            end
         end
      end
   end

   // Monitor: compare DUT outputs against the scoreboard every falling edge.
   always @(negedge clk) begin
      if (mon_en) begin
         tests++;
         if (frame_valid !== (sb_re.size() != 0)) begin
            fails++;
            $display("FAIL mon_frame_valid: got %b required %b", frame_valid, sb_re.size() != 0);
         end
         tests++;
         if (s_ready !== (sb_re.size() < 2)) begin
            fails++;
            $display("FAIL mon_s_ready: got %b required %b", s_ready, sb_re.size() < 2);
         end
         tests++;
         if (err_pulse !== exp_err) begin
            fails++;
            $display("FAIL mon_err_pulse: got %b required %b", err_pulse, exp_err);
         end
         if (frame_valid === 1'b1 && sb_re.size() != 0) begin
            tests++;
            if (frame_re !== sb_re[0] || frame_im !== sb_im[0]) begin
               fails++;
               $display("FAIL mon_frame_data: got re=%h im=%h required re=%h im=%h",
                        frame_re, frame_im, sb_re[0], sb_im[0]);
            end
         end
      end
   end

   function automatic cplx_t mk(input int r, input int i);
      cplx_t c;
      c.re = 16'(r);
      c.im = 16'(i);
      return c;
   endfunction

   // One clock cycle of stimulus, entered and left at a falling edge.
   task automatic cycle(input logic v, input cplx_t smp, input logic last,
                        input logic fr, output logic acc);
      s_valid     = v;
      s_re        = smp.re;
      s_im        = smp.im;
      s_last      = last;
      frame_ready = fr;
      acc         = v && s_ready;
      @(negedge clk);
      s_valid = 1'b0;
      s_last  = 1'b0;
   endtask

   task automatic send(input cplx_t smp, input logic last, input logic fr);
      logic        acc;
      int unsigned n;
      acc = 1'b0;
      n   = 0;
      while (!acc && n < 64) begin
         cycle(1'b1, smp, last, fr, acc);
         n++;
      end
      tests++;
      if (!acc) begin
         fails++;
         $display("FAIL send_timeout: got no accept after %0d cycles required accept", n);
      end
   endtask

   task automatic idle(input logic fr);
      logic acc;
      cycle(1'b0, mk(0, 0), 1'b0, fr, acc);
   endtask

   task automatic test_reset;
      rst_n = 1'b0; s_valid = 1'b0; s_re = '0; s_im = '0; s_last = 1'b0; frame_ready = 1'b0;
      #23;
      tests++;
      if (s_ready !== 1'b1) begin fails++; $display("FAIL rst_s_ready: got %b required 1", s_ready); end
      tests++;
      if (frame_valid !== 1'b0) begin fails++; $display("FAIL rst_frame_valid: got %b required 0", frame_valid); end
      tests++;
      if (err_pulse !== 1'b0) begin fails++; $display("FAIL rst_err_pulse: got %b required 0", err_pulse); end
      tests++;
      if (frame_re !== '0 || frame_im !== '0) begin
         fails++; $display("FAIL rst_frame_bus: got re=%h im=%h required 0", frame_re, frame_im);
      end
      @(negedge clk);
      rst_n  = 1'b1;
      mon_en = 1;
      @(negedge clk);
   endtask

   task automatic test_single_frame;
      for (int k = 0; k < N; k++) begin
         tests++;
         if (frame_valid !== 1'b0) begin fails++; $display("FAIL single_early_valid: got %b required 0 at k=%0d", frame_valid, k); end
         send(mk(k, -k), k == N - 1, 1'b0);
      end
      tests++;
      if (frame_valid !== 1'b1) begin fails++; $display("FAIL single_valid: got %b required 1", frame_valid); end
      for (int k = 0; k < N; k++) begin
         tests++;
         if (frame_re[k*W +: W] !== 16'(k) || frame_im[k*W +: W] !== 16'(-k)) begin
            fails++;
            $display("FAIL single_slice: k=%0d got re=%h im=%h required re=%h im=%h",
                     k, frame_re[k*W +: W], frame_im[k*W +: W], 16'(k), 16'(-k));
         end
      end
      tests++;
      if (err_pulse !== 1'b0) begin fails++; $display("FAIL single_err: got %b required 0", err_pulse); end
      idle(1'b1);
      tests++;
      if (frame_valid !== 1'b0) begin fails++; $display("FAIL single_consumed: got %b required 0", frame_valid); end
   endtask

   task automatic test_back_to_back;
      logic acc;
      int   pos[$];
      for (int i = 0; i < 4 * N; i++) begin
         cycle(1'b1, mk(int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535))),
               (i % N) == N - 1, 1'b1, acc);
         tests++;
         if (acc !== 1'b1) begin fails++; $display("FAIL stream_ready: got %b required 1 at i=%0d", acc, i); end
         if (frame_valid === 1'b1) pos.push_back(i);
      end
      tests++;
      if (pos.size() != 4) begin
         fails++; $display("FAIL stream_windows: got %0d required 4", pos.size());
      end else begin
         for (int j = 0; j < 4; j++) begin
            tests++;
            if (pos[j] != 15 + 16 * j) begin
               fails++; $display("FAIL stream_window_pos: got %0d required %0d", pos[j], 15 + 16 * j);
            end
         end
      end
      idle(1'b1);
      tests++;
      if (frame_valid !== 1'b0) begin fails++; $display("FAIL stream_drain: got %b required 0", frame_valid); end
   endtask

   task automatic test_backpressure;
      logic           acc;
      int             n_acc;
      logic [N*W-1:0] snap_re, snap_im;
      n_acc = 0;
      for (int c = 0; c < 40; c++) begin
         cycle(1'b1, mk(100 + n_acc, 500 + n_acc), (n_acc % N) == N - 1, 1'b0, acc);
         if (acc) begin
            n_acc++;
            if (n_acc == 32) begin
               tests++;
               if (s_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_drop: got %b required 0", s_ready); end
            end
         end
      end
      tests++;
      if (n_acc != 32) begin fails++; $display("FAIL bp_accept_count: got %0d required 32", n_acc); end
      snap_re = frame_re;
      snap_im = frame_im;
      for (int c = 0; c < 5; c++) begin
         cycle(1'b1, mk(100 + n_acc, 500 + n_acc), 1'b0, 1'b0, acc);
         tests++;
         if (frame_re !== snap_re || frame_im !== snap_im || frame_valid !== 1'b1 || s_ready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold: got valid=%b ready=%b stable=%b required valid=1 ready=0 stable=1",
                     frame_valid, s_ready, (frame_re === snap_re) && (frame_im === snap_im));
         end
      end
      tests++;
      if (frame_re[0 +: W] !== 16'd100 || frame_re[(N-1)*W +: W] !== 16'd115) begin
         fails++; $display("FAIL bp_frame0: got k0=%h k15=%h required 0064 0073", frame_re[0 +: W], frame_re[(N-1)*W +: W]);
      end
      idle(1'b1);
      tests++;
      if (frame_valid !== 1'b1 || s_ready !== 1'b1) begin
         fails++; $display("FAIL bp_next: got valid=%b ready=%b required 1 1", frame_valid, s_ready);
      end
      for (int k = 0; k < N; k++) begin
         tests++;
         if (frame_re[k*W +: W] !== 16'(116 + k) || frame_im[k*W +: W] !== 16'(516 + k)) begin
            fails++;
            $display("FAIL bp_frame1: k=%0d got re=%h im=%h required re=%h im=%h",
                     k, frame_re[k*W +: W], frame_im[k*W +: W], 16'(116 + k), 16'(516 + k));
         end
      end
      idle(1'b1);
      tests++;
      if (frame_valid !== 1'b0) begin fails++; $display("FAIL bp_drain: got %b required 0", frame_valid); end
   endtask

   task automatic test_early_last;
      for (int k = 0; k < 6; k++) send(mk(900 + k, 0), k == 5, 1'b0);
      tests++;
      if (err_pulse !== 1'b1 || frame_valid !== 1'b0) begin
         fails++; $display("FAIL early_err: got err=%b valid=%b required err=1 valid=0", err_pulse, frame_valid);
      end
      idle(1'b0);
      tests++;
      if (err_pulse !== 1'b0) begin fails++; $display("FAIL early_err_width: got %b required 0", err_pulse); end
      for (int k = 0; k < N; k++) send(mk(200 + k, 300 - k), k == N - 1, 1'b0);
      tests++;
      if (frame_valid !== 1'b1 || frame_re[0 +: W] !== 16'd200 || frame_im[(N-1)*W +: W] !== 16'd285) begin
         fails++;
         $display("FAIL early_refill: got valid=%b k0=%h im15=%h required 1 00c8 011d",
                  frame_valid, frame_re[0 +: W], frame_im[(N-1)*W +: W]);
      end
      idle(1'b1);
   endtask

   task automatic test_missing_last;
      for (int k = 0; k < N; k++) send(mk(-k * 7, k * 3), 1'b0, 1'b0);
      tests++;
      if (frame_valid !== 1'b1 || err_pulse !== 1'b1) begin
         fails++; $display("FAIL miss_flags: got valid=%b err=%b required 1 1", frame_valid, err_pulse);
      end
      for (int k = 0; k < N; k++) begin
         tests++;
         if (frame_re[k*W +: W] !== 16'(-k * 7) || frame_im[k*W +: W] !== 16'(k * 3)) begin
            fails++; $display("FAIL miss_slice: k=%0d got re=%h im=%h", k, frame_re[k*W +: W], frame_im[k*W +: W]);
         end
      end
      idle(1'b1);
      tests++;
      if (err_pulse !== 1'b0) begin fails++; $display("FAIL miss_err_width: got %b required 0", err_pulse); end
   endtask

   task automatic test_reset_mid_frame;
      for (int k = 0; k < N; k++) send(mk(40 + k, 0), k == N - 1, 1'b0);
      for (int k = 0; k < 9; k++) send(mk(60 + k, 0), 1'b0, 1'b0);
      tests++;
      if (frame_valid !== 1'b1) begin fails++; $display("FAIL mid_held: got %b required 1", frame_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (frame_valid !== 1'b0 || s_ready !== 1'b1 || frame_re !== '0 || frame_im !== '0) begin
         fails++;
         $display("FAIL mid_async: got valid=%b ready=%b re=%h required valid=0 ready=1 re=0",
                  frame_valid, s_ready, frame_re);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < N; k++) send(mk(700 + k, -700 - k), k == N - 1, 1'b0);
      for (int k = 0; k < N; k++) begin
         tests++;
         if (frame_valid !== 1'b1 || frame_re[k*W +: W] !== 16'(700 + k) || frame_im[k*W +: W] !== 16'(-700 - k)) begin
            fails++;
            $display("FAIL mid_refill: k=%0d got valid=%b re=%h im=%h", k, frame_valid,
                     frame_re[k*W +: W], frame_im[k*W +: W]);
         end
      end
      idle(1'b1);
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_backpressure();
      test_early_last();
      test_missing_last();
      test_reset_mid_frame();
      idle(1'b0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
